// File: rtl/seq_pc_update_pkg.sv
// Shared Y86-64 definitions used by the SEQ processor stages.
//   word_w  : architectural word width in bits
//   icode_t : instruction code encodings (4'hC-4'hF are invalid, no entry)
package seq_pc_update_pkg;

  localparam int unsigned WORD_W = 64;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

endpackage

// File: rtl/seq_pc_update.sv
// SEQ Y86-64 PC-update stage. Selects the next program counter from the
// current instruction's outcome and registers it for the fetch stage.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, forces newPC to 0
//   PC    : PC of the executing instruction (held on halt/invalid)
//   icode : instruction code
//   cnd   : branch condition, used only by jXX
//   valC  : constant word (jump/call target)
//   valM  : memory read value (ret address)
//   valP  : address of the sequentially next instruction
//   newPC : registered next PC
module seq_pc_update
  import seq_pc_update_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] PC,
  input  logic [3:0]        icode,
  input  logic              cnd,
  input  logic [WORD_W-1:0] valC,
  input  logic [WORD_W-1:0] valM,
  input  logic [WORD_W-1:0] valP,
  output logic [WORD_W-1:0] newPC
);

  logic [WORD_W-1:0] nextPC;

  always_comb begin
    nextPC = PC;
    case (icode)
      I_CALL:   nextPC = valC;
      I_JXX:    nextPC = cnd ? valC : valP;
      I_RET:    nextPC = valM;
      I_HALT:   nextPC = PC;
      I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
                nextPC = valP;
      // Invalid codes hold the PC; the status logic raises the exception.
      default:  nextPC = PC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) newPC <= '0;
    else     newPC <= nextPC;
  end

endmodule

// File: tb/tb_seq_pc_update.sv
// Self-checking bench for seq_pc_update: directed literal cases plus
// randomized stimulus compared each cycle against a behavioural model.
module tb_seq_pc_update;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] PC = '0, valC = '0, valM = '0, valP = '0;
  logic [3:0]  icode = 4'h1;
  logic        cnd = 1'b0;
  logic [63:0] newPC;

  int nchk = 0;
  int nfail = 0;

  seq_pc_update dut (
    .clk(clk), .rst(rst), .PC(PC), .icode(icode), .cnd(cnd),
    .valC(valC), .valM(valM), .valP(valP), .newPC(newPC)
  );

  always #5 clk = ~clk;

  // Next PC straight from the ISA description of each instruction class.
  function automatic logic [63:0] model(input logic r, input logic [3:0] ic,
      input logic c, input logic [63:0] pc, input logic [63:0] vc,
      input logic [63:0] vm, input logic [63:0] vp);
    if (r) return 64'h0;
    if (ic == 4'h8) return vc;
    if (ic == 4'h9) return vm;
    if (ic == 4'h7) return c ? vc : vp;
    if (ic inside {[4'h1:4'h6], 4'hA, 4'hB}) return vp;
    return pc;
  endfunction

  logic [63:0] exp_pc;
  logic        exp_valid = 1'b0;

  always @(posedge clk) begin
    exp_pc    <= model(rst, icode, cnd, PC, valC, valM, valP);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      nchk++;
      if (newPC !== exp_pc) begin
        nfail++;
        $display("FAIL model_cmp t=%0t newPC=%h expected=%h", $time, newPC, exp_pc);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] want);
    nchk++;
    if (newPC !== want) begin
      nfail++;
      $display("FAIL %s newPC=%h expected=%h", name, newPC, want);
    end
  endtask

  // Drive after the falling edge, clock once, then check the literal.
  task automatic step(input string name, input logic r, input logic [3:0] ic,
      input logic c, input logic [63:0] exp_lit);
    @(negedge clk);
    rst = r; icode = ic; cnd = c;
    @(posedge clk);
    #1;
    check(name, exp_lit);
  endtask

  initial begin
    PC = 64'h0; valC = 64'd10; valM = 64'd20; valP = 64'd30;
    step("reset", 1'b1, 4'h8, 1'b0, 64'd0);
    step("after_reset", 1'b0, 4'h3, 1'b0, 64'd30);

    begin
      logic [3:0] seq_codes [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
      foreach (seq_codes[i]) step($sformatf("seq_ic%0h", seq_codes[i]), 1'b0, seq_codes[i], 1'b0, 64'd30);
    end

    step("call", 1'b0, 4'h8, 1'b0, 64'd10);
    step("ret", 1'b0, 4'h9, 1'b0, 64'd20);
    step("jxx_nt", 1'b0, 4'h7, 1'b0, 64'd30);
    step("jxx_t", 1'b0, 4'h7, 1'b1, 64'd10);
    step("cnd_ignored", 1'b0, 4'h3, 1'b1, 64'd30);
    step("ret_cnd_ignored", 1'b0, 4'h9, 1'b1, 64'd20);

    @(negedge clk);
    PC = 64'h40; valP = 64'h41;
    step("halt", 1'b0, 4'h0, 1'b0, 64'h40);
    step("invalid_f", 1'b0, 4'hF, 1'b0, 64'h40);
    step("invalid_c", 1'b0, 4'hC, 1'b1, 64'h40);

    // Mid-cycle input changes must not reach newPC before the next edge.
    #1;
    icode = 4'h8; valC = 64'hFFFF_FFFF_FFFF_FFF8;
    #2;
    check("mid_cycle_hold", 64'h40);
    @(posedge clk);
    #1;
    check("wide_call", 64'hFFFF_FFFF_FFFF_FFF8);

    // Reset asserted with a live selection wins at the edge.
    step("reset_wins", 1'b1, 4'h8, 1'b1, 64'd0);

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst   = ($urandom_range(15) == 0);
      icode = 4'($urandom_range(15));
      cnd   = 1'($urandom_range(1));
      PC    = {$urandom, $urandom};
      valC  = {$urandom, $urandom};
      valM  = {$urandom, $urandom};
      valP  = {$urandom, $urandom};
      #2;
      if (n % 7 == 0) begin
        // Glitch the inputs between edges; the edge samples the final values.
        icode = 4'($urandom_range(15));
        valC  = {$urandom, $urandom};
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
